// File: rtl/limbus_nios_ocimem_ctrl_if.sv
// Debug RAM port bundle between the OCI memory controller and its RAM.
// The controller drives address, data and strobes; the RAM returns read data one cycle after ram_re.
interface limbus_nios_ocimem_ctrl_if;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  modport master (
    output ram_addr,
    output ram_wdata,
    output ram_we,
    output ram_re,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr,
    input  ram_wdata,
    input  ram_we,
    input  ram_re,
    output ram_rdata
  );
endinterface

// File: rtl/limbus_nios_ocimem_ctrl.sv
// OCI debug memory controller: turns JTAG sysclk-stage strobes into single-cycle debug RAM
// reads/writes, with an auto-incrementing address register and sticky error reporting.
module limbus_nios_ocimem_ctrl (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [37:0]                    jdo,
  input  logic                           take_action_ocimem_a,
  input  logic                           take_no_action_ocimem_a,
  input  logic                           take_action_ocimem_b,
  input  logic                           debugack,
  output logic [31:0]                    MonDReg,
  output logic                           monitor_ready,
  output logic                           monitor_error,
  limbus_nios_ocimem_ctrl_if.master      ram
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR_ISSUE = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [7:0]  MonAReg;
  logic [31:0] wr_data;
  logic        any_strobe;
  logic        multi_strobe;
  logic        accept;
  logic        jdo_unused;

  assign any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign multi_strobe = (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_no_action_ocimem_a & take_action_ocimem_b);
  assign accept       = (state == IDLE) && any_strobe && debugack;
  assign jdo_unused   = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (take_action_ocimem_b)      state_d = WR_ISSUE;
          else if (take_action_ocimem_a) state_d = jdo[35] ? RD_ISSUE : IDLE;
          else                           state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  state_d = IDLE;
      WR_ISSUE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      MonAReg       <= '0;
      MonDReg       <= '0;
      wr_data       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      state         <= state_d;
      monitor_ready <= (state_d == IDLE);
      // Accepted strobes clear the error unless a lower-priority strobe was dropped alongside;
      // any strobe that is refused (busy or CPU not halted) sets it.
      if (any_strobe)
        monitor_error <= accept ? multi_strobe : 1'b1;
      if (accept) begin
        if (take_action_ocimem_b)      wr_data <= jdo[34:3];
        else if (take_action_ocimem_a) MonAReg <= jdo[33:26];
      end
      if (state == RD_WAIT) begin
        MonDReg <= ram.ram_rdata;
        MonAReg <= MonAReg + 8'd1;
      end
      if (state == WR_ISSUE) begin
        MonDReg <= wr_data;
        MonAReg <= MonAReg + 8'd1;
      end
    end
  end

  assign ram.ram_addr  = MonAReg;
  assign ram.ram_re    = (state == RD_ISSUE);
  assign ram.ram_we    = (state == WR_ISSUE);
  assign ram.ram_wdata = (state == WR_ISSUE) ? wr_data : '0;

endmodule

// File: tb/tb_limbus_nios_ocimem_ctrl.sv
// Bench for limbus_nios_ocimem_ctrl: per-cycle vector table plus a reset-during-read sequence,
// with a small behavioural debug RAM answering reads one cycle after ram_re.
module tb_limbus_nios_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        debugack;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  limbus_nios_ocimem_ctrl_if ram_bus ();

  limbus_nios_ocimem_ctrl dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .debugack                (debugack),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .ram                     (ram_bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (ram_bus.ram_we) mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
    if (ram_bus.ram_re) ram_bus.ram_rdata <= mem[ram_bus.ram_addr];
  end

  typedef struct {
    logic        a;
    logic        na;
    logic        b;
    logic        dbg;
    logic [37:0] jdo;
    logic [75:0] exp;
  } vec_t;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  vec_t        vt [22];

  function automatic logic [37:0] ja(input logic rd, input logic [7:0] addr);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[33:26] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    return j;
  endfunction

  function automatic logic [75:0] ex(input logic rdy, input logic err, input logic re, input logic we,
                                     input logic [7:0] addr, input logic [31:0] wd, input logic [31:0] md);
    return {rdy, err, re, we, addr, wd, md};
  endfunction

  function automatic vec_t mk(input logic a, input logic na, input logic b, input logic dbg,
                              input logic [37:0] j, input logic [75:0] e);
    vec_t v;
    v.a = a; v.na = na; v.b = b; v.dbg = dbg; v.jdo = j; v.exp = e;
    return v;
  endfunction

  function automatic logic [75:0] observed();
    return {monitor_ready, monitor_error, ram_bus.ram_re, ram_bus.ram_we,
            ram_bus.ram_addr, ram_bus.ram_wdata, MonDReg};
  endfunction

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got rdy/err/re/we/addr/wdata/mdr=%h required %h", name, act, req);
  endtask

  task automatic drive(input logic a, input logic na, input logic b, input logic dbg, input logic [37:0] j);
    take_action_ocimem_a    = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b    = b;
    debugack                = dbg;
    jdo                     = j;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    ram_bus.ram_rdata = '0;

    // Per-cycle vectors: inputs held for one clock, outputs compared just after that edge.
    vt[0]  = mk(1, 0, 0, 1, ja(0, 8'h10),      ex(1, 0, 0, 0, 8'h10, 32'h0, 32'h0));
    vt[1]  = mk(0, 0, 1, 1, jb(32'hDEADBEEF),  ex(0, 0, 0, 1, 8'h10, 32'hDEADBEEF, 32'h0));
    vt[2]  = mk(0, 0, 0, 1, '0,                ex(1, 0, 0, 0, 8'h11, 32'h0, 32'hDEADBEEF));
    vt[3]  = mk(1, 0, 0, 1, ja(1, 8'h20),      ex(0, 0, 1, 0, 8'h20, 32'h0, 32'hDEADBEEF));
    vt[4]  = mk(0, 0, 0, 1, '0,                ex(0, 0, 0, 0, 8'h20, 32'h0, 32'hDEADBEEF));
    vt[5]  = mk(0, 0, 0, 1, '0,                ex(1, 0, 0, 0, 8'h21, 32'h0, 32'hA5000020));
    vt[6]  = mk(1, 0, 0, 1, ja(1, 8'h10),      ex(0, 0, 1, 0, 8'h10, 32'h0, 32'hA5000020));
    vt[7]  = mk(0, 0, 0, 1, '0,                ex(0, 0, 0, 0, 8'h10, 32'h0, 32'hA5000020));
    vt[8]  = mk(0, 0, 0, 1, '0,                ex(1, 0, 0, 0, 8'h11, 32'h0, 32'hDEADBEEF));
    vt[9]  = mk(1, 0, 0, 1, ja(0, 8'hFF),      ex(1, 0, 0, 0, 8'hFF, 32'h0, 32'hDEADBEEF));
    vt[10] = mk(0, 1, 0, 1, '0,                ex(0, 0, 1, 0, 8'hFF, 32'h0, 32'hDEADBEEF));
    vt[11] = mk(0, 0, 0, 1, '0,                ex(0, 0, 0, 0, 8'hFF, 32'h0, 32'hDEADBEEF));
    vt[12] = mk(0, 0, 0, 1, '0,                ex(1, 0, 0, 0, 8'h00, 32'h0, 32'hA50000FF));
    vt[13] = mk(0, 0, 1, 0, jb(32'h12345678),  ex(1, 1, 0, 0, 8'h00, 32'h0, 32'hA50000FF));
    vt[14] = mk(0, 0, 0, 1, '0,                ex(1, 1, 0, 0, 8'h00, 32'h0, 32'hA50000FF));
    vt[15] = mk(1, 0, 0, 1, ja(0, 8'h30),      ex(1, 0, 0, 0, 8'h30, 32'h0, 32'hA50000FF));
    vt[16] = mk(0, 1, 1, 1, jb(32'hCAFEF00D),  ex(0, 1, 0, 1, 8'h30, 32'hCAFEF00D, 32'hA50000FF));
    vt[17] = mk(0, 0, 0, 1, '0,                ex(1, 1, 0, 0, 8'h31, 32'h0, 32'hCAFEF00D));
    vt[18] = mk(0, 1, 0, 1, '0,                ex(0, 0, 1, 0, 8'h31, 32'h0, 32'hCAFEF00D));
    vt[19] = mk(0, 0, 0, 1, '0,                ex(0, 0, 0, 0, 8'h31, 32'h0, 32'hCAFEF00D));
    vt[20] = mk(0, 0, 1, 1, jb(32'h11111111),  ex(1, 1, 0, 0, 8'h32, 32'h0, 32'hA5000031));
    vt[21] = mk(0, 0, 0, 1, '0,                ex(1, 1, 0, 0, 8'h32, 32'h0, 32'hA5000031));

    reset_n = 1'b0;
    drive(0, 0, 0, 1, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("reset_state", observed(), ex(1, 0, 0, 0, 8'h00, 32'h0, 32'h0));

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].a, vt[i].na, vt[i].b, vt[i].dbg, vt[i].jdo);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), observed(), vt[i].exp);
    end

    // Reset pulsed while the read is waiting for RAM data.
    @(negedge clk);
    drive(0, 1, 0, 1, '0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 1, '0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("reset_in_rd_wait", observed(), ex(1, 0, 0, 0, 8'h00, 32'h0, 32'h0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 check($sformatf("post_reset_idle%0d", k), observed(), ex(1, 0, 0, 0, 8'h00, 32'h0, 32'h0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, got running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/limbus_nios_ocimem_ctrl.md
LIMBUS_NIOS_OCIMEM_CTRL -- requirements
Module: limbus_nios_ocimem_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock for all logic.
REQ-002 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port jdo, input, 38: debug command/data word from the JTAG sysclk stage.
REQ-004 SHALL have port take_action_ocimem_a, input, 1: one-cycle strobe that loads the address and optionally starts a read.
REQ-005 SHALL have port take_no_action_ocimem_a, input, 1: one-cycle strobe that starts a streaming read.
REQ-006 SHALL have port take_action_ocimem_b, input, 1: one-cycle strobe that starts a streaming write.
REQ-007 SHALL have port debugack, input, 1: CPU is halted in debug mode.
REQ-008 SHALL have port MonDReg, output, 32: monitor data register, readback value to the JTAG tck stage.
REQ-009 SHALL have port monitor_ready, output, 1: last command complete.
REQ-010 SHALL have port monitor_error, output, 1: last command rejected.
REQ-011 SHALL have port ram_addr, output, 8: debug RAM word address.
REQ-012 SHALL have port ram_wdata, output, 32: debug RAM write data.
REQ-013 SHALL have port ram_we, output, 1: debug RAM write enable.
REQ-014 SHALL have port ram_re, output, 1: debug RAM read enable.
REQ-015 SHALL have port ram_rdata, input, 32: debug RAM read data, valid exactly one cycle after ram_re.

Function
REQ-016 SHALL hold an internal 8-bit address register MonAReg; ram_addr SHALL equal MonAReg during every RAM access.
REQ-017 SHALL implement the FSM states IDLE, RD_ISSUE, RD_WAIT and WR_ISSUE; strobes SHALL be accepted only in IDLE.
REQ-018 take_action_ocimem_a in IDLE (cycle N) SHALL load MonAReg from jdo[33:26].
REQ-019 If jdo[35]=1 on that strobe, the FSM SHALL go to RD_ISSUE; otherwise it SHALL stay in IDLE with monitor_ready=1.
REQ-020 take_no_action_ocimem_a in IDLE (cycle N) SHALL move the FSM to RD_ISSUE.
REQ-021 Read timing: RD_ISSUE at N+1 drives ram_re=1; RD_WAIT at N+2 captures ram_rdata into MonDReg at the end of N+2; MonAReg post-increments at that same edge; monitor_ready=1 from N+3.
REQ-022 take_action_ocimem_b in IDLE (cycle N) SHALL capture jdo[34:3] and move the FSM to WR_ISSUE.
REQ-023 WR_ISSUE at N+1 SHALL drive ram_we=1 and ram_wdata equal to the captured data; MonDReg SHALL take the same data; MonAReg SHALL post-increment; monitor_ready=1 from N+2.
REQ-024 monitor_ready SHALL clear in the cycle after any accepted strobe that starts a RAM access.
REQ-025 ram_re and ram_we SHALL be single-cycle pulses and SHALL never be asserted together; ram_wdata SHALL be 0 when ram_we=0.
REQ-026 MonAReg increment SHALL wrap from 0xFF to 0x00.
REQ-027 Simultaneous strobes: priority SHALL be ocimem_b > ocimem_a > no_action_a; the lower-priority strobes SHALL be dropped and monitor_error set.
REQ-028 Any strobe while the FSM is not in IDLE SHALL be dropped; monitor_error SHALL be set; the access in flight SHALL complete unaffected.
REQ-029 A strobe with debugack=0 SHALL cause no RAM access and no MonAReg/MonDReg change; monitor_error SHALL be set; monitor_ready SHALL stay 1.
REQ-030 monitor_error SHALL be sticky and SHALL clear only on the next strobe accepted in IDLE with debugack=1.

Reset
REQ-031 On reset_n=0 the block SHALL asynchronously force: FSM=IDLE, MonAReg=0, MonDReg=0, monitor_ready=1, monitor_error=0, ram_re=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-032 Reset asserted mid-access SHALL abort the access, and no RAM strobe SHALL be issued after reset_n deasserts.

Verification
REQ-033 Bench SHALL cover: load address then write — debugack=1, take_action_ocimem_a with jdo[33:26]=0x10, jdo[35]=0, then take_action_ocimem_b with jdo[34:3]=0xDEADBEEF -> ram_we pulse at addr 0x10 with data 0xDEADBEEF, MonAReg=0x11, monitor_ready=1 two cycles after the strobe.
REQ-034 Bench SHALL cover: read with address load — take_action_ocimem_a with jdo[33:26]=0x10, jdo[35]=1, RAM returning 0xDEADBEEF -> ram_re at N+1, MonDReg=0xDEADBEEF and monitor_ready=1 at N+3, MonAReg=0x11.
REQ-035 Bench SHALL cover: address wrap — MonAReg=0xFF, then take_no_action_ocimem_a -> read at 0xFF, MonAReg=0x00.
REQ-036 Bench SHALL cover: debugack=0 with take_action_ocimem_b -> no ram_we, monitor_error=1, monitor_ready=1; a following valid strobe clears monitor_error.
REQ-037 Bench SHALL cover: take_action_ocimem_b and take_no_action_ocimem_a in the same cycle -> write only, monitor_error=1; a strobe during RD_WAIT is dropped and the read completes.
REQ-038 Bench SHALL cover: reset_n pulsed low during RD_WAIT -> all outputs at reset values, and no ram_re after release.
